// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (IF) and data (D) ports.
// D wins contention unless IF has been denied MAX_IF_WAIT consecutive cycles.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_IF_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int CW = $clog2(MAX_IF_WAIT + 1);

    typedef enum logic [1:0] {IDLE, IF_RD, D_RD} state_t;

    state_t        r_state;
    logic [CW-1:0] r_starve_cnt;
    logic          r_if_rvalid;
    logic          r_d_rvalid;

    logic          w_if_wins;
    logic          w_gnt_if;
    logic          w_gnt_d;

    always_comb begin
        w_if_wins = (r_starve_cnt == CW'(MAX_IF_WAIT));
        w_gnt_if  = !reset && if_req_i && (!d_req_i || w_if_wins);
        w_gnt_d   = !reset && d_req_i && !w_gnt_if;
    end

    // Address/data bus is forced to zero whenever nothing is granted
    always_comb begin
        mem_en_o    = w_gnt_if || w_gnt_d;
        mem_we_o    = w_gnt_d && d_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_gnt_if) begin
            mem_addr_o = if_addr_i;
        end else if (w_gnt_d) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    assign if_gnt_o = w_gnt_if;
    assign d_gnt_o  = w_gnt_d;

    // State tracks which requester owns the read returning next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_if_rvalid  <= 1'b0;
            r_d_rvalid   <= 1'b0;
        end else begin
            case (1'b1)
                w_gnt_if:            r_state <= IF_RD;
                (w_gnt_d && !d_we_i): r_state <= D_RD;
                default:             r_state <= IDLE;
            endcase
            r_if_rvalid <= w_gnt_if;
            r_d_rvalid  <= w_gnt_d && !d_we_i;
            if (if_req_i && !w_gnt_if) begin
                if (!w_if_wins)
                    r_starve_cnt <= r_starve_cnt + CW'(1);
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    // Reset is applied combinationally so a pre-reset grant never returns data
    always_comb begin
        if_rvalid_o = !reset && r_if_rvalid && (r_state == IF_RD);
        d_rvalid_o  = !reset && r_d_rvalid && (r_state == D_RD);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
    logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0;
    logic        if_gnt_o, if_rvalid_o, d_gnt_o, d_rvalid_o, mem_en_o, mem_we_o;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_IF_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Environment RAM: synchronous, one access per cycle
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o[7:0]] <= mem_wdata_o;
            else          mem_rdata_i <= ram[mem_addr_o[7:0]];
        end
    end

    // Reference model: wait count, one pending response, shadow memory contents
    logic [31:0] shadow [256];
    int          m_wait = 0;
    logic        m_pif = 1'b0, m_pd = 1'b0;
    logic [31:0] m_pdata = '0;
    logic        e_ig, e_dg, e_en, e_we, e_irv, e_drv;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;

    task automatic model_comb();
        e_ig = 0; e_dg = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
        e_irv = 0; e_drv = 0; e_ird = 0; e_drd = 0;
        if (!reset) begin
            e_ig   = if_req_i && (!d_req_i || m_wait >= MAXW);
            e_dg   = d_req_i && !e_ig;
            e_en   = e_ig || e_dg;
            e_we   = e_dg && d_we_i;
            e_addr = e_ig ? if_addr_i : (e_dg ? d_addr_i : 32'h0);
            e_wd   = e_dg ? d_wdata_i : 32'h0;
            e_irv  = m_pif;
            e_drv  = m_pd;
            e_ird  = m_pif ? m_pdata : 32'h0;
            e_drd  = m_pd ? m_pdata : 32'h0;
        end
    endtask

    task automatic model_seq();
        if (reset) begin
            m_wait = 0; m_pif = 0; m_pd = 0;
        end else begin
            m_pif = e_ig;
            m_pd  = e_dg && !d_we_i;
            if (e_dg && d_we_i) shadow[d_addr_i[7:0]] = d_wdata_i;
            if (e_ig)      m_pdata = shadow[if_addr_i[7:0]];
            else if (m_pd) m_pdata = shadow[d_addr_i[7:0]];
            if (if_req_i && !e_ig) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
            else                   m_wait = 0;
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dd);
        @(negedge clk);
        reset = r; if_req_i = ir; if_addr_i = ia;
        d_req_i = dr; d_we_i = dw; d_addr_i = da; d_wdata_i = dd;
        #1 model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_seq();
    endtask

    task automatic test_reset();
        drive(1, 1, 32'h10, 1, 0, 32'h3, 32'h1);
        checks++;
        if ({if_gnt_o, d_gnt_o, mem_en_o, mem_we_o, if_rvalid_o, d_rvalid_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {if_gnt_o, d_gnt_o, mem_en_o, mem_we_o, if_rvalid_o, d_rvalid_o});
        end
        checks++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h want 0", mem_addr_o, mem_wdata_o,
                     if_rdata_o, d_rdata_o);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_if_only();
        drive(0, 1, 32'h10, 0, 0, 0, 0);
        checks++;
        if ({if_gnt_o, d_gnt_o, mem_en_o, mem_we_o, mem_addr_o} !== {4'b1010, 32'h10}) begin
            errors++;
            $display("FAIL if_only_grant got %b %h want 1010 00000010",
                     {if_gnt_o, d_gnt_o, mem_en_o, mem_we_o}, mem_addr_o);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h00500093 || d_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL if_only_data got v=%b d=%h dv=%b want v=1 d=00500093 dv=0",
                     if_rvalid_o, if_rdata_o, d_rvalid_o);
        end
        tick();
    endtask

    task automatic test_d_write_read();
        drive(0, 0, 0, 1, 1, 32'h3, 32'hDEADBEEF);
        checks++;
        if (d_gnt_o !== 1'b1 || mem_we_o !== 1'b1 || mem_wdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL d_write got g=%b we=%b wd=%h want 1 1 deadbeef", d_gnt_o, mem_we_o, mem_wdata_o);
        end
        tick();
        drive(0, 0, 0, 1, 0, 32'h3, 32'h0);
        checks++;
        if (d_gnt_o !== 1'b1 || mem_we_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL d_read_issue got g=%b we=%b rv=%b want 1 0 0", d_gnt_o, mem_we_o, d_rvalid_o);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEADBEEF || if_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL d_read_data got rv=%b d=%h want 1 deadbeef", d_rvalid_o, d_rdata_o);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [9:0] pat = '0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 32'h10, 1, 0, 32'h3, 0);
            pat[i] = if_gnt_o;
            checks++;
            if (d_gnt_o !== !if_gnt_o || if_rvalid_o !== e_irv || d_rvalid_o !== e_drv ||
                if_rdata_o !== e_ird || d_rdata_o !== e_drd) begin
                errors++;
                $display("FAIL starve_cycle%0d got g=%b%b rv=%b%b want g=%b%b rv=%b%b", i,
                         if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, e_ig, e_dg, e_irv, e_drv);
            end
            tick();
        end
        checks++;
        if (pat !== 10'h210) begin
            errors++;
            $display("FAIL starve_pattern got %b want 1000010000", pat);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== e_ird || d_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL starve_last got v=%b d=%h want 1 %h", if_rvalid_o, if_rdata_o, e_ird);
        end
        tick();
    endtask

    task automatic test_if_dwrite();
        drive(0, 1, 32'h20, 1, 1, 32'h5, 32'hCAFE0005);
        checks++;
        if ({if_gnt_o, d_gnt_o, mem_we_o} !== 3'b011) begin
            errors++;
            $display("FAIL ifdw_first got %b want 011", {if_gnt_o, d_gnt_o, mem_we_o});
        end
        tick();
        drive(0, 1, 32'h20, 0, 0, 0, 0);
        checks++;
        if (if_gnt_o !== 1'b1 || d_rvalid_o !== 1'b0 || mem_addr_o !== 32'h20) begin
            errors++;
            $display("FAIL ifdw_second got g=%b drv=%b a=%h want 1 0 20", if_gnt_o, d_rvalid_o, mem_addr_o);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== shadow[8'h20] || d_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL ifdw_data got v=%b d=%h want 1 %h", if_rvalid_o, if_rdata_o, shadow[8'h20]);
        end
        tick();
    endtask

    task automatic test_reset_pending();
        for (int i = 0; i < 3; i++) begin drive(0, 1, 32'h10, 1, 0, 32'h3, 0); tick(); end
        drive(0, 1, 32'h10, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (if_rvalid_o !== 1'b0 || if_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_pending got v=%b d=%h want 0 0", if_rvalid_o, if_rdata_o);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({if_rvalid_o, d_rvalid_o, mem_en_o, if_gnt_o, d_gnt_o} !== 5'b0 || mem_addr_o !== 0) begin
            errors++;
            $display("FAIL rst_after got %b a=%h want 00000 0",
                     {if_rvalid_o, d_rvalid_o, mem_en_o, if_gnt_o, d_gnt_o}, mem_addr_o);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 32'h10, 1, 0, 32'h3, 0);
            checks++;
            if (if_gnt_o !== (i == 4)) begin
                errors++;
                $display("FAIL rst_cnt_clear cyc%0d got ifg=%b want %b", i, if_gnt_o, i == 4);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(0, 1, 32'($urandom_range(1, 255)), 0, 0, 0, 0);
            else            drive(0, 0, 0, 1, 0, 32'($urandom_range(1, 255)), 0);
            checks++;
            if (if_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0 || mem_addr_o !== e_addr) begin
                errors++;
                $display("FAIL alt_req%0d got rv=%b%b a=%h want 00 %h", i, if_rvalid_o, d_rvalid_o,
                         mem_addr_o, e_addr);
            end
            tick();
            drive(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (mem_en_o !== 1'b0 || mem_addr_o !== 32'h0 || if_rvalid_o !== e_irv ||
                d_rvalid_o !== e_drv || if_rdata_o !== e_ird || d_rdata_o !== e_drd) begin
                errors++;
                $display("FAIL alt_idle%0d got en=%b a=%h rv=%b%b want 0 0 %b%b", i, mem_en_o,
                         mem_addr_o, if_rvalid_o, d_rvalid_o, e_irv, e_drv);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic ir = 0, dr = 0, dw = 0, r;
        logic [31:0] ia = 0, da = 0, dd = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ir && $urandom_range(0, 1) == 1) begin ir = 1; ia = 32'($urandom_range(0, 15)); end
            else if (ir && $urandom_range(0, 15) == 0) ir = 0;
            if (!dr && $urandom_range(0, 1) == 1) begin
                dr = 1; dw = 1'($urandom_range(0, 1));
                da = 32'($urandom_range(0, 15)); dd = $urandom;
            end else if (dr && $urandom_range(0, 15) == 0) dr = 0;
            r = ($urandom_range(0, 39) == 0);
            drive(r, ir, ia, dr, dw, da, dd);
            checks++;
            if ({if_gnt_o, d_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !==
                {e_ig, e_dg, e_en, e_we, e_addr, e_wd}) begin
                errors++;
                $display("FAIL rand_bus%0d got %b %h %h want %b %h %h", n,
                         {if_gnt_o, d_gnt_o, mem_en_o, mem_we_o}, mem_addr_o, mem_wdata_o,
                         {e_ig, e_dg, e_en, e_we}, e_addr, e_wd);
            end
            checks++;
            if ({if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o} !== {e_irv, e_ird, e_drv, e_drd}) begin
                errors++;
                $display("FAIL rand_resp%0d got %b %h %b %h want %b %h %b %h", n, if_rvalid_o,
                         if_rdata_o, d_rvalid_o, d_rdata_o, e_irv, e_ird, e_drv, e_drd);
            end
            if (e_ig) ir = 0;
            if (e_dg) dr = 0;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            shadow[i] = ram[i];
        end
        ram[16] = 32'h00500093;
        shadow[16] = 32'h00500093;
        test_reset();
        test_if_only();
        test_d_write_read();
        test_starvation();
        test_if_dwrite();
        test_reset_pending();
        test_alternate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
